// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus outgoing valid/ready beat stream for fifo_rd_streamer.
// master = the streamer, slave = FIFO model and downstream sink.
interface fifo_rd_streamer_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_r_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_r_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_r_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Read-domain FIFO consumer: 3-entry prefetch buffer re-presenting FIFO words
// as a valid/ready stream framed into PKT_LEN-beat packets, with packet count.
module fifo_rd_streamer #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  fifo_rd_streamer_if.master   bus,
  output logic [CNT_W-1:0]     pkt_count
);
  localparam int BCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(PKT_LEN - 1);

  logic [WIDTH-1:0]  r_buf [3];
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [BCNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0]  r_pkt_count;

  logic       w_rd_en;
  logic       w_push;
  logic       w_pop;
  logic       w_valid;
  logic       w_last;
  logic [2:0] w_pending;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read enable depends only on registered occupancy and the empty flag, so
  // m_ready never reaches fifo_r_en; reset holds it low so no word is lost.
  always_comb begin
    w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
    w_rd_en   = !rrst && !bus.fifo_empty && (w_pending < 3'd3);
    w_push    = r_inflight;
    w_valid   = (r_occ != 2'd0);
    w_pop     = w_valid && bus.m_ready;
    w_last    = w_valid && (r_bcnt == LAST_BEAT);
  end

  assign bus.fifo_r_en = w_rd_en;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = r_buf[r_rd_ptr];
  assign bus.m_last    = w_last;
  assign pkt_count     = r_pkt_count;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_buf       <= '{default: '0};
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_bcnt      <= '0;
      r_pkt_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.fifo_rdata;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
        r_bcnt   <= (r_bcnt == LAST_BEAT) ? '0 : r_bcnt + BCNT_W'(1);
        if (w_last) r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based FIFO model with 1-cycle read latency,
// reference is the pushed word order with framing derived from beat index.
module tb_fifo_rd_streamer;
  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic [CNT_W-1:0] pkt_count;

  fifo_rd_streamer_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_streamer #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .bus       (bus),
    .pkt_count (pkt_count)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_data[$];
  bit               got_last[$];
  int               got_cyc[$];
  int               rd_cyc[$];
  int               cyc, reads, pops, max_outs, overreads;
  bit               hold_empty;

  task automatic clear_obs();
    got_data.delete(); got_last.delete(); got_cyc.delete(); rd_cyc.delete();
    reads = 0; pops = 0; max_outs = 0; overreads = 0;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    hold_empty = 1'b0;
    fifo_q.delete(); exp_q.delete();
    clear_obs();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    cyc = 0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: drive ready, record handshake/read, advance the FIFO model.
  task automatic step(input bit rdy);
    bit ren;
    bus.m_ready = rdy;
    bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    ren = bus.fifo_r_en;
    if (bus.m_valid && rdy) begin
      got_data.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
      got_cyc.push_back(cyc);
      pops++;
    end
    if (ren) begin
      reads++;
      rd_cyc.push_back(cyc);
    end
    if (reads - pops > max_outs) max_outs = reads - pops;
    assert (reads - pops <= 3) else $error("FAIL occupancy: outstanding %0d above 3", reads - pops);
    @(posedge rclk);
    #1;
    if (ren) begin
      if (fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
      else begin bus.fifo_rdata = 8'hEE; overreads++; end
    end
    bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
    cyc++;
    @(negedge rclk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if ({bus.fifo_r_en, bus.m_valid, bus.m_last, bus.m_data, pkt_count} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: got r_en=%b v=%b l=%b d=%h pc=%0d required all 0",
                 c, bus.fifo_r_en, bus.m_valid, bus.m_last, bus.m_data, pkt_count);
      end
      step(1'b1);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
    for (int c = 0; c < 40 && got_data.size() < 8; c++) step(1'b1);
    n_cmp++;
    if (rd_cyc.size() == 0 || rd_cyc[0] != 0) begin
      n_bad++; $display("FAIL stream_first_read: got %0d reads, first read cycle required 0", rd_cyc.size());
    end
    n_cmp++;
    if (got_data.size() != 8) begin
      n_bad++; $display("FAIL stream_beats: got %0d required 8", got_data.size());
    end
    n_cmp++;
    if (got_cyc.size() == 0 || got_cyc[0] != 2) begin
      n_bad++; $display("FAIL stream_latency: first beat cycle got %0d required 2",
                        got_cyc.size() ? got_cyc[0] : -1);
    end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'(i % PKT_LEN == PKT_LEN - 1)} ||
          got_cyc[i] != got_cyc[0] + i) begin
        n_bad++;
        $display("FAIL stream_beat%0d: got d=%h l=%b cyc=%0d required d=%h l=%b cyc=%0d", i,
                 got_data[i], got_last[i], got_cyc[i], exp_q[i], (i % PKT_LEN == PKT_LEN - 1), got_cyc[0] + i);
      end
    end
    n_cmp++;
    if (pkt_count !== CNT_W'(2)) begin
      n_bad++; $display("FAIL stream_pkt_count: got %0d required 2", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      step(1'b0);
      if (c >= 1) begin
        n_cmp++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11 || bus.m_last !== 1'b0) begin
          n_bad++; $display("FAIL bp_hold c%0d: got v=%b d=%h l=%b required v=1 d=11 l=0",
                            c, bus.m_valid, bus.m_data, bus.m_last);
        end
      end
    end
    n_cmp++;
    if (reads != 3 || bus.fifo_r_en !== 1'b0) begin
      n_bad++; $display("FAIL bp_reads: got %0d reads r_en=%b required 3 reads r_en=0", reads, bus.fifo_r_en);
    end
    bus.m_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.fifo_r_en !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready_to_ren: got r_en=%b required 0 while buffer full", bus.fifo_r_en);
    end
    bus.m_ready = 1'b0;
    for (int c = 0; c < 40 && got_data.size() < 8; c++) step(1'b1);
    n_cmp++;
    if (got_data.size() != 8) begin
      n_bad++; $display("FAIL bp_beats: got %0d required 8", got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'(i % PKT_LEN == PKT_LEN - 1)} ||
          got_cyc[i] != got_cyc[0] + i) begin
        n_bad++; $display("FAIL bp_beat%0d: got d=%h l=%b cyc=%0d required d=%h cyc=%0d",
                          i, got_data[i], got_last[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
      end
    end
    n_cmp++;
    if (pkt_count !== CNT_W'(2)) begin
      n_bad++; $display("FAIL bp_pkt_count: got %0d required 2", pkt_count);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 20; i++) push_word(8'($urandom));
    for (int c = 0; c < 120 && got_data.size() < 20; c++) step(c % 2 == 0);
    n_cmp++;
    if (got_data.size() != 20 || max_outs > 3 || overreads != 0) begin
      n_bad++; $display("FAIL toggle_counts: got beats=%0d max_outs=%0d overreads=%0d required 20/<=3/0",
                        got_data.size(), max_outs, overreads);
    end
    for (int i = 0; i < got_data.size() && i < 20; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'(i % PKT_LEN == PKT_LEN - 1)}) begin
        n_bad++; $display("FAIL toggle_beat%0d: got d=%h l=%b required d=%h l=%b", i,
                          got_data[i], got_last[i], exp_q[i], (i % PKT_LEN == PKT_LEN - 1));
      end
    end
    n_cmp++;
    if (pkt_count !== CNT_W'(5)) begin
      n_bad++; $display("FAIL toggle_pkt_count: got %0d required 5", pkt_count);
    end
  endtask

  task automatic test_random();
    int pushed;
    do_reset();
    pushed = 0;
    for (int c = 0; c < 500 && got_data.size() < 48; c++) begin
      if (pushed < 48 && $urandom_range(2) == 0) begin
        for (int k = 0; k < int'($urandom_range(3, 1)) && pushed < 48; k++) begin
          push_word(8'($urandom));
          pushed++;
        end
      end
      hold_empty = ($urandom_range(7) == 0);
      step($urandom_range(3) != 0);
    end
    hold_empty = 1'b0;
    n_cmp++;
    if (got_data.size() != 48 || max_outs > 3 || overreads != 0) begin
      n_bad++; $display("FAIL random_counts: got beats=%0d max_outs=%0d overreads=%0d required 48/<=3/0",
                        got_data.size(), max_outs, overreads);
    end
    for (int i = 0; i < got_data.size() && i < 48; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'(i % PKT_LEN == PKT_LEN - 1)}) begin
        n_bad++; $display("FAIL random_beat%0d: got d=%h l=%b required d=%h l=%b", i,
                          got_data[i], got_last[i], exp_q[i], (i % PKT_LEN == PKT_LEN - 1));
      end
    end
    n_cmp++;
    if (pkt_count !== CNT_W'(48 / PKT_LEN)) begin
      n_bad++; $display("FAIL random_pkt_count: got %0d required %0d", pkt_count, 48 / PKT_LEN);
    end
  endtask

  task automatic test_empty_inflight();
    logic [CNT_W-1:0] pc_before;
    do_reset();
    pc_before = pkt_count;
    for (int i = 0; i < 3; i++) push_word(8'hA0 + 8'(i));
    for (int c = 0; c < 12; c++) step(1'b1);
    n_cmp++;
    if (reads != 3 || overreads != 0 || got_data.size() != 3) begin
      n_bad++; $display("FAIL empty_reads: got reads=%0d overreads=%0d beats=%0d required 3/0/3",
                        reads, overreads, got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'b0}) begin
        n_bad++; $display("FAIL empty_beat%0d: got d=%h l=%b required d=%h l=0",
                          i, got_data[i], got_last[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (pkt_count !== pc_before) begin
      n_bad++; $display("FAIL empty_pkt_count: got %0d required %0d", pkt_count, pc_before);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'h21 + 8'(i));
    for (int c = 0; c < 30 && got_data.size() < 4; c++) step(1'b1);
    n_cmp++;
    if (pkt_count !== CNT_W'(1)) begin
      n_bad++; $display("FAIL midop_pre_pkt: got %0d required 1", pkt_count);
    end
    exp_q.delete();
    clear_obs();
    for (int i = 0; i < 8; i++) push_word(8'h31 + 8'(i));
    repeat (3) step(1'b0);
    n_cmp++;
    if (reads != 3 || bus.m_valid !== 1'b1) begin
      n_bad++; $display("FAIL midop_setup: got reads=%0d v=%b required 3/1", reads, bus.m_valid);
    end
    rrst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.fifo_r_en, bus.m_valid, bus.m_last, bus.m_data, pkt_count} !== '0) begin
      n_bad++; $display("FAIL midop_async: got r_en=%b v=%b l=%b d=%h pc=%0d required all 0",
                        bus.fifo_r_en, bus.m_valid, bus.m_last, bus.m_data, pkt_count);
    end
    exp_q = fifo_q;
    clear_obs();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    for (int c = 0; c < 40 && got_data.size() < 5; c++) step(1'b1);
    n_cmp++;
    if (got_data.size() != 5) begin
      n_bad++; $display("FAIL midop_beats: got %0d required 5", got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 5; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {exp_q[i], 1'(i % PKT_LEN == PKT_LEN - 1)}) begin
        n_bad++; $display("FAIL midop_beat%0d: got d=%h l=%b required d=%h l=%b", i,
                          got_data[i], got_last[i], exp_q[i], (i % PKT_LEN == PKT_LEN - 1));
      end
    end
    n_cmp++;
    if (pkt_count !== CNT_W'(1)) begin
      n_bad++; $display("FAIL midop_pkt_count: got %0d required 1", pkt_count);
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_random();
    test_empty_inflight();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
